// File: rtl/fifo_prog_flags_if.sv
// Handshake bundle between a stream producer/consumer and fifo_prog_flags.
// The FIFO binds to the slave modport; the driving side binds to master.
interface fifo_prog_flags_if #(
    parameter int WordLength = 8,
    parameter int AddrWidth  = 4
);
    logic                  flush_i;
    logic                  wr_i;
    logic [WordLength-1:0] w_data_i;
    logic                  rd_i;
    logic                  clr_err_i;
    logic [WordLength-1:0] r_data_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  almost_empty_o;
    logic                  almost_full_o;
    logic [AddrWidth:0]    count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output flush_i, wr_i, w_data_i, rd_i, clr_err_i,
        input  r_data_o, empty_o, full_o, almost_empty_o, almost_full_o,
               count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, wr_i, w_data_i, rd_i, clr_err_i,
        output r_data_o, empty_o, full_o, almost_empty_o, almost_full_o,
               count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_prog_flags.sv
// Single-clock first-word-fall-through FIFO with fill level, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_prog_flags #(
    parameter int WordLength    = 8,
    parameter int AddrWidth     = 4,
    parameter int AlmostFullTh  = 12,
    parameter int AlmostEmptyTh = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fifo_prog_flags_if.slave  bus
);
    localparam int Depth = 1 << AddrWidth;
    localparam logic [AddrWidth:0] DepthC = (AddrWidth + 1)'(Depth);
    localparam logic [AddrWidth:0] AfThC  = (AddrWidth + 1)'(AlmostFullTh);
    localparam logic [AddrWidth:0] AeThC  = (AddrWidth + 1)'(AlmostEmptyTh);

    logic [WordLength-1:0] mem_q [Depth];
    logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AddrWidth:0]    count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty, full;
    logic wr_accept, rd_accept;
    logic overflow_set, underflow_set;

    assign empty = (count_q == '0);
    assign full  = (count_q == DepthC);

    // A full FIFO still takes a write when a pop frees the slot in the same cycle.
    assign wr_accept     = bus.wr_i && (!full || bus.rd_i) && !bus.flush_i;
    assign rd_accept     = bus.rd_i && !empty && !bus.flush_i;
    assign overflow_set  = bus.wr_i && full && !bus.rd_i && !bus.flush_i;
    assign underflow_set = bus.rd_i && empty && !bus.flush_i;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Setting an error outranks clearing it in the same cycle.
        overflow_d  = overflow_set  ? 1'b1 : (bus.clr_err_i ? 1'b0 : overflow_q);
        underflow_d = underflow_set ? 1'b1 : (bus.clr_err_i ? 1'b0 : underflow_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk_i) begin
        if (wr_accept) mem_q[wr_ptr_q] <= bus.w_data_i;
    end

    assign bus.r_data_o       = mem_q[rd_ptr_q];
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_empty_o = (count_q <= AeThC);
    assign bus.almost_full_o  = (count_q >= AfThC);
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.underflow_o    = underflow_q;
endmodule

// File: tb/tb_fifo_prog_flags.sv
// Randomised and directed bench for fifo_prog_flags against a queue-based model,
// plus a small directed pass on a 16-bit x 8-deep build.
module tb_fifo_prog_flags;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_prog_flags_if #(.WordLength(8), .AddrWidth(4)) bus ();
    fifo_prog_flags #(
        .WordLength(8), .AddrWidth(4), .AlmostFullTh(12), .AlmostEmptyTh(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    fifo_prog_flags_if #(.WordLength(16), .AddrWidth(3)) bus2 ();
    fifo_prog_flags #(
        .WordLength(16), .AddrWidth(3), .AlmostFullTh(6), .AlmostEmptyTh(1)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy is just the queue length.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge(input bit wr, input bit rd, input bit fl, input bit clr,
                              input logic [7:0] d);
        bit ovf_new = 1'b0;
        bit unf_new = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            bit was_full  = (mq.size() == 16);
            bit was_empty = (mq.size() == 0);
            if (rd && was_empty) unf_new = 1'b1;
            if (wr && was_full && !rd) ovf_new = 1'b1;
            if (rd && !was_empty) void'(mq.pop_front());
            if (wr && (!was_full || rd)) mq.push_back(d);
        end
        if (ovf_new) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (unf_new) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    endtask

    task automatic check_all();
        int n = mq.size();
        check("count", 32'(bus.count_o), n);
        check("empty", 32'(bus.empty_o), 32'(n == 0));
        check("full", 32'(bus.full_o), 32'(n == 16));
        check("almost_empty", 32'(bus.almost_empty_o), 32'(n <= 2));
        check("almost_full", 32'(bus.almost_full_o), 32'(n >= 12));
        check("overflow", 32'(bus.overflow_o), 32'(m_ovf));
        check("underflow", 32'(bus.underflow_o), 32'(m_unf));
        if (n > 0) check("r_data", 32'(bus.r_data_o), 32'(mq[0]));
    endtask

    // Drive one cycle of inputs (called just after an edge), then check after the next edge.
    task automatic step(input bit wr, input bit rd, input bit fl, input bit clr,
                        input logic [7:0] d);
        bus.wr_i      = wr;
        bus.rd_i      = rd;
        bus.flush_i   = fl;
        bus.clr_err_i = clr;
        bus.w_data_i  = d;
        @(posedge clk);
        model_edge(wr, rd, fl, clr, d);
        #1;
        check_all();
    endtask

    initial begin
        bus.wr_i = 0; bus.rd_i = 0; bus.flush_i = 0; bus.clr_err_i = 0; bus.w_data_i = '0;
        bus2.wr_i = 0; bus2.rd_i = 0; bus2.flush_i = 0; bus2.clr_err_i = 0; bus2.w_data_i = '0;
        rst = 1'b1;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill 0x00..0x0F then drain in order.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i));
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00);

        // Overflow on a full FIFO, then clear.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
        step(1, 0, 0, 0, 8'hAA);
        step(0, 0, 0, 1, 8'h00);

        // Drain, then simultaneous read/write on an empty FIFO.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'h55);
        step(0, 0, 0, 1, 8'h00);

        // Refill, then 20 cycles of read+write while full across pointer wrap.
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 8'(8'h60 + i));
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 8'(8'h80 + i));

        // Flush to zero, build count 5, flush with a write present, then write 0x3C.
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'hC0 + i));
        step(1, 0, 1, 0, 8'hEE);
        step(1, 0, 0, 0, 8'h3C);

        // Randomised traffic, biased so the FIFO visits both ends.
        for (int i = 0; i < 600; i++) begin
            bit phase_fill = ((i / 60) % 2) == 0;
            bit wr = ($urandom_range(99) < (phase_fill ? 75 : 30));
            bit rd = ($urandom_range(99) < (phase_fill ? 30 : 75));
            bit fl = ($urandom_range(99) < 2);
            bit cl = ($urandom_range(99) < 5);
            step(wr, rd, fl, cl, 8'($urandom));
        end

        // Count 7, then asynchronous reset in the middle of the cycle.
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h17);
        step(1, 0, 0, 0, 8'h18);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #2;
        rst = 1'b0;
        step(1, 0, 0, 0, 8'h99);
        step(0, 1, 0, 0, 8'h00);

        // 16-bit x 8-deep build: fill to full, overflow, drain in order.
        for (int i = 0; i < 8; i++) begin
            bus2.wr_i = 1'b1;
            bus2.w_data_i = 16'(16'hA000 + i);
            @(posedge clk);
            #1;
            check("w16_count", 32'(bus2.count_o), i + 1);
            check("w16_full", 32'(bus2.full_o), 32'(i == 7));
            check("w16_almost_full", 32'(bus2.almost_full_o), 32'(i >= 5));
        end
        bus2.w_data_i = 16'hBEEF;
        @(posedge clk);
        #1;
        check("w16_overflow", 32'(bus2.overflow_o), 32'd1);
        check("w16_count_hold", 32'(bus2.count_o), 32'd8);
        bus2.wr_i = 1'b0;
        bus2.rd_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("w16_r_data", 32'(bus2.r_data_o), 32'(16'hA000 + i));
            @(posedge clk);
            #1;
        end
        bus2.rd_i = 1'b0;
        check("w16_empty", 32'(bus2.empty_o), 32'd1);
        check("w16_underflow", 32'(bus2.underflow_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
